// File: rtl/effects_pkg.sv
// Shared types for the effects scheduler: scheduler FSM states and the
// one-bit channel tag that travels through the in-flight FIFO.
package effects_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    DRAIN
  } fsm_state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_tag_t;

endpackage

// File: rtl/tag_fifo.sv
// Small in-order FIFO holding the channel tag of every sample in flight
// through the effects datapath. Pushes when full and pops when empty are ignored.
module tag_fifo #(
  parameter int depth = 4,
  parameter int width = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic [$clog2(depth):0]   count
);

  localparam int AW    = $clog2(depth);
  localparam int CNT_W = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != CNT_W'(depth));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count define
  // which entries are valid, so clearing the array would add logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/effects_scheduler.sv
// Two-channel front end that shares one effects datapath: holds one sample per
// channel, issues them round-robin with a minimum gap, and routes results back.
module effects_scheduler
  import effects_pkg::*;
#(
  parameter int bits_per_level = 12,
  parameter int fxp_size       = 16,
  parameter int gain_size      = 11,
  parameter int tag_depth      = 4,
  parameter int issue_gap      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid_a,
  input  logic                      i_valid_b,
  input  logic [bits_per_level-1:0] i_sample_a,
  input  logic [bits_per_level-1:0] i_sample_b,
  output logic                      o_ready_a,
  output logic                      o_ready_b,
  input  logic [gain_size-1:0]      i_gain_a,
  input  logic [gain_size-1:0]      i_gain_b,
  output logic                      o_fx_valid,
  output logic [bits_per_level-1:0] o_fx_sample,
  output logic [gain_size-1:0]      o_fx_gain,
  input  logic                      i_fx_valid,
  input  logic [fxp_size-1:0]       i_fx_sample,
  output logic                      o_valid_a,
  output logic                      o_valid_b,
  output logic [fxp_size-1:0]       o_sample_a,
  output logic [fxp_size-1:0]       o_sample_b,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int CNT_W = $clog2(tag_depth) + 1;
  localparam int GAP_W = (issue_gap > 2) ? $clog2(issue_gap - 1) : 1;

  fsm_state_t                state;
  logic [GAP_W-1:0]          gap_cnt;
  chan_tag_t                 rr_ptr;

  logic                      hold_full_a;
  logic                      hold_full_b;
  logic [bits_per_level-1:0] hold_sample_a;
  logic [bits_per_level-1:0] hold_sample_b;
  logic [gain_size-1:0]      hold_gain_a;
  logic [gain_size-1:0]      hold_gain_b;

  chan_tag_t                 sel_ch;
  logic [bits_per_level-1:0] sel_sample;
  logic [gain_size-1:0]      sel_gain;
  logic                      gain_ok;
  logic                      issue_now;
  logic                      drain_now;

  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [0:0]                head_tag;
  logic                      fx_pop;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(tag_depth));
  assign fx_pop     = i_fx_valid && !fifo_empty;

  assign o_ready_a  = !hold_full_a;
  assign o_ready_b  = !hold_full_b;
  assign o_busy     = hold_full_a || hold_full_b || !fifo_empty;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_ch = CH_A;
    if (hold_full_a && hold_full_b) sel_ch = rr_ptr;
    else if (hold_full_b)           sel_ch = CH_B;
    sel_sample = (sel_ch == CH_B) ? hold_sample_b : hold_sample_a;
    sel_gain   = (sel_ch == CH_B) ? hold_gain_b   : hold_gain_a;
    // A gain change is only safe once nothing issued under the old gain is in flight.
    gain_ok    = (sel_gain == o_fx_gain) || fifo_empty;
    issue_now  = (state == IDLE) && (hold_full_a || hold_full_b) && !fifo_full && gain_ok;
    drain_now  = (state == IDLE) && (hold_full_a || hold_full_b) && !gain_ok;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      rr_ptr      <= CH_A;
      o_fx_valid  <= 1'b0;
      o_fx_sample <= '0;
      o_fx_gain   <= '0;
    end else begin
      o_fx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_now) begin
            o_fx_valid  <= 1'b1;
            o_fx_sample <= sel_sample;
            o_fx_gain   <= sel_gain;
            rr_ptr      <= (rr_ptr == CH_A) ? CH_B : CH_A;
            if (issue_gap > 1) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(issue_gap - 2);
            end
          end else if (drain_now) begin
            state <= DRAIN;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        DRAIN: begin
          if (fifo_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding registers: freed by their own issue, loaded only while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_a   <= 1'b0;
      hold_full_b   <= 1'b0;
      hold_sample_a <= '0;
      hold_sample_b <= '0;
      hold_gain_a   <= '0;
      hold_gain_b   <= '0;
    end else begin
      if (issue_now && sel_ch == CH_A) begin
        hold_full_a <= 1'b0;
      end else if (i_valid_a && !hold_full_a) begin
        hold_full_a   <= 1'b1;
        hold_sample_a <= i_sample_a;
        hold_gain_a   <= i_gain_a;
      end
      if (issue_now && sel_ch == CH_B) begin
        hold_full_b <= 1'b0;
      end else if (i_valid_b && !hold_full_b) begin
        hold_full_b   <= 1'b1;
        hold_sample_b <= i_sample_b;
        hold_gain_b   <= i_gain_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_a  <= 1'b0;
      o_valid_b  <= 1'b0;
      o_sample_a <= '0;
      o_sample_b <= '0;
      o_err      <= 1'b0;
    end else begin
      o_valid_a <= 1'b0;
      o_valid_b <= 1'b0;
      if (fx_pop) begin
        if (head_tag == 1'b1) begin
          o_valid_b  <= 1'b1;
          o_sample_b <= i_fx_sample;
        end else begin
          o_valid_a  <= 1'b1;
          o_sample_a <= i_fx_sample;
        end
      end
      if ((i_valid_a && hold_full_a) || (i_valid_b && hold_full_b) ||
          (i_fx_valid && fifo_empty))
        o_err <= 1'b1;
    end
  end

  tag_fifo #(
    .depth (tag_depth),
    .width (1)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_now),
    .push_data (sel_ch),
    .pop       (fx_pop),
    .pop_data  (head_tag),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_effects_scheduler.sv
// Directed bench for effects_scheduler: issue order, gain drain, error flags,
// FIFO-full stall and asynchronous reset, with hand-computed expectations.
module tb_effects_scheduler;

  localparam int BPL = 12;
  localparam int FXP = 16;
  localparam int GS  = 11;
  localparam int TD  = 4;
  localparam int IG  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_valid_a, i_valid_b;
  logic [BPL-1:0] i_sample_a, i_sample_b;
  logic           o_ready_a, o_ready_b;
  logic [GS-1:0]  i_gain_a, i_gain_b;
  logic           o_fx_valid;
  logic [BPL-1:0] o_fx_sample;
  logic [GS-1:0]  o_fx_gain;
  logic           i_fx_valid;
  logic [FXP-1:0] i_fx_sample;
  logic           o_valid_a, o_valid_b;
  logic [FXP-1:0] o_sample_a, o_sample_b;
  logic           o_busy;
  logic           o_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  effects_scheduler #(
    .bits_per_level (BPL),
    .fxp_size       (FXP),
    .gain_size      (GS),
    .tag_depth      (TD),
    .issue_gap      (IG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid_a   (i_valid_a),
    .i_valid_b   (i_valid_b),
    .i_sample_a  (i_sample_a),
    .i_sample_b  (i_sample_b),
    .o_ready_a   (o_ready_a),
    .o_ready_b   (o_ready_b),
    .i_gain_a    (i_gain_a),
    .i_gain_b    (i_gain_b),
    .o_fx_valid  (o_fx_valid),
    .o_fx_sample (o_fx_sample),
    .o_fx_gain   (o_fx_gain),
    .i_fx_valid  (i_fx_valid),
    .i_fx_sample (i_fx_sample),
    .o_valid_a   (o_valid_a),
    .o_valid_b   (o_valid_b),
    .o_sample_a  (o_sample_a),
    .o_sample_b  (o_sample_b),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [BPL-1:0] s, input logic [GS-1:0] g);
    i_valid_a  = 1'b1;
    i_sample_a = s;
    i_gain_a   = g;
  endtask

  task automatic drive_b(input logic [BPL-1:0] s, input logic [GS-1:0] g);
    i_valid_b  = 1'b1;
    i_sample_b = s;
    i_gain_b   = g;
  endtask

  task automatic clear_strobes();
    i_valid_a = 1'b0;
    i_valid_b = 1'b0;
  endtask

  task automatic ret(input logic [FXP-1:0] v);
    i_fx_valid  = 1'b1;
    i_fx_sample = v;
    tick();
    i_fx_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_valid_a = 1'b0; i_valid_b = 1'b0;
    i_sample_a = '0;  i_sample_b = '0;
    i_gain_a = '0;    i_gain_b = '0;
    i_fx_valid = 1'b0; i_fx_sample = '0;
    #1 rst = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_ready_a", o_ready_a, 1);
    check("rst_ready_b", o_ready_b, 1);
    check("rst_fx_valid", o_fx_valid, 0);
    check("rst_fx_gain", o_fx_gain, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_valid_a", o_valid_a, 0);
    check("rst_sample_a", o_sample_a, 0);
    rst = 1'b1;
    tick();

    // Channel A only, result returned two cycles after issue
    drive_a(12'h123, 11'h010);
    tick();
    clear_strobes();
    check("a_only_ready_drop", o_ready_a, 0);
    check("a_only_busy", o_busy, 1);
    tick();
    check("a_only_issue", o_fx_valid, 1);
    check("a_only_fx_sample", o_fx_sample, 12'h123);
    check("a_only_fx_gain", o_fx_gain, 11'h010);
    check("a_only_ready_back", o_ready_a, 1);
    tick();
    check("a_only_issue_pulse", o_fx_valid, 0);
    tick();
    ret(16'h0246);
    check("a_only_valid_a", o_valid_a, 1);
    check("a_only_sample_a", o_sample_a, 16'h0246);
    check("a_only_valid_b", o_valid_b, 0);
    tick();
    check("a_only_valid_a_pulse", o_valid_a, 0);
    check("a_only_sample_hold", o_sample_a, 16'h0246);
    check("a_only_idle_busy", o_busy, 0);
    check("a_only_err", o_err, 0);

    // Round-robin A,B,A,B at gap 2, then FIFO full stall
    do_reset();
    drive_a(12'h101, 11'h010);
    drive_b(12'h202, 11'h010);
    tick();
    clear_strobes();
    check("rr_ready_a", o_ready_a, 0);
    check("rr_ready_b", o_ready_b, 0);
    tick();
    check("rr_issue1", o_fx_valid, 1);
    check("rr_issue1_a", o_fx_sample, 12'h101);
    drive_a(12'h103, 11'h010);
    tick();
    clear_strobes();
    check("rr_gap1", o_fx_valid, 0);
    tick();
    check("rr_issue2", o_fx_valid, 1);
    check("rr_issue2_b", o_fx_sample, 12'h202);
    drive_b(12'h204, 11'h010);
    tick();
    clear_strobes();
    check("rr_gap2", o_fx_valid, 0);
    tick();
    check("rr_issue3", o_fx_valid, 1);
    check("rr_issue3_a", o_fx_sample, 12'h103);
    tick();
    check("rr_gap3", o_fx_valid, 0);
    tick();
    check("rr_issue4", o_fx_valid, 1);
    check("rr_issue4_b", o_fx_sample, 12'h204);
    drive_a(12'h105, 11'h010);
    tick();
    clear_strobes();
    tick();
    check("full_no_issue1", o_fx_valid, 0);
    check("full_hold_a", o_ready_a, 0);
    tick();
    check("full_no_issue2", o_fx_valid, 0);
    ret(16'h1111);
    check("ret1_valid_a", o_valid_a, 1);
    check("ret1_sample_a", o_sample_a, 16'h1111);
    check("ret1_valid_b", o_valid_b, 0);
    check("ret1_still_stalled", o_fx_valid, 0);
    ret(16'h2222);
    check("ret2_valid_b", o_valid_b, 1);
    check("ret2_sample_b", o_sample_b, 16'h2222);
    check("after_pop_issue", o_fx_valid, 1);
    check("after_pop_sample", o_fx_sample, 12'h105);
    ret(16'h3333);
    check("ret3_valid_a", o_valid_a, 1);
    check("ret3_sample_a", o_sample_a, 16'h3333);
    ret(16'h4444);
    check("ret4_valid_b", o_valid_b, 1);
    check("ret4_sample_b", o_sample_b, 16'h4444);
    ret(16'h5555);
    check("ret5_valid_a", o_valid_a, 1);
    check("ret5_sample_a", o_sample_a, 16'h5555);
    tick();
    check("rr_drained_busy", o_busy, 0);
    check("rr_err", o_err, 0);

    // Gain change forces DRAIN before B issues
    drive_a(12'h111, 11'h010);
    tick();
    clear_strobes();
    tick();
    check("drain_a_issue", o_fx_valid, 1);
    check("drain_a_gain", o_fx_gain, 11'h010);
    drive_b(12'h222, 11'h020);
    tick();
    clear_strobes();
    check("drain_wait1", o_fx_valid, 0);
    tick();
    check("drain_wait2", o_fx_valid, 0);
    check("drain_gain_held", o_fx_gain, 11'h010);
    tick();
    check("drain_wait3", o_fx_valid, 0);
    ret(16'h0AAA);
    check("drain_ret_valid_a", o_valid_a, 1);
    check("drain_ret_sample_a", o_sample_a, 16'h0AAA);
    check("drain_wait4", o_fx_valid, 0);
    tick();
    check("drain_wait5", o_fx_valid, 0);
    check("drain_gain_held2", o_fx_gain, 11'h010);
    tick();
    check("drain_b_issue", o_fx_valid, 1);
    check("drain_b_sample", o_fx_sample, 12'h222);
    check("drain_b_gain", o_fx_gain, 11'h020);
    tick();
    tick();
    ret(16'h0BBB);
    check("drain_ret_valid_b", o_valid_b, 1);
    check("drain_ret_sample_b", o_sample_b, 16'h0BBB);
    check("drain_err", o_err, 0);

    // Result with nothing in flight
    do_reset();
    ret(16'h0999);
    check("orphan_err", o_err, 1);
    check("orphan_valid_a", o_valid_a, 0);
    check("orphan_valid_b", o_valid_b, 0);
    tick();
    check("orphan_err_sticky", o_err, 1);

    // Strobe into a full holding register
    do_reset();
    drive_a(12'h0AA, 11'h010);
    tick();
    check("ovf_ready_a", o_ready_a, 0);
    check("ovf_err_before", o_err, 0);
    drive_a(12'h0BB, 11'h030);
    tick();
    clear_strobes();
    check("ovf_err", o_err, 1);
    check("ovf_issue", o_fx_valid, 1);
    check("ovf_first_sample", o_fx_sample, 12'h0AA);
    check("ovf_first_gain", o_fx_gain, 11'h010);
    tick();
    tick();
    ret(16'h0155);
    check("ovf_valid_a", o_valid_a, 1);
    check("ovf_sample_a", o_sample_a, 16'h0155);
    check("ovf_err_sticky", o_err, 1);
    tick();
    check("ovf_dropped_ready", o_ready_a, 1);
    check("ovf_dropped_busy", o_busy, 0);

    // Asynchronous reset mid-flight
    drive_a(12'h077, 11'h040);
    tick();
    clear_strobes();
    tick();
    check("mid_issue", o_fx_valid, 1);
    check("mid_fx_sample", o_fx_sample, 12'h077);
    check("mid_busy", o_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_fx_valid", o_fx_valid, 0);
    check("async_fx_sample", o_fx_sample, 0);
    check("async_fx_gain", o_fx_gain, 0);
    check("async_sample_a", o_sample_a, 0);
    check("async_err", o_err, 0);
    check("async_busy", o_busy, 0);
    check("async_ready_a", o_ready_a, 1);
    #1 rst = 1'b1;
    tick();
    tick();
    ret(16'h0333);
    check("post_rst_err", o_err, 1);
    check("post_rst_valid_a", o_valid_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/effects_scheduler.md
EFFECTS_SCHEDULER -- requirements
Module: effects_scheduler

Interface
REQ-001 Parameter: bits_per_level, default 12, ADC sample width (signed, two's complement).
REQ-002 Parameter: fxp_size, default 16, processed sample width returned by the effects datapath.
REQ-003 Parameter: gain_size, default 11, gain word width (bits_per_gain_frac fractional bits, remainder integer).
REQ-004 Parameter: tag_depth, default 4, maximum in-flight samples (power of two, >= 2).
REQ-005 Parameter: issue_gap, default 2, minimum cycles between consecutive issues (>= 1).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 i_valid_a / i_valid_b  in  1 each  channel A/B sample strobe.
REQ-009 i_sample_a / i_sample_b  in  bits_per_level each  channel A/B input sample.
REQ-010 o_ready_a / o_ready_b  out  1 each  channel A/B holding register empty.
REQ-011 i_gain_a / i_gain_b  in  gain_size each  per-channel gain, sampled when the channel's sample is accepted.
REQ-012 o_fx_valid  out  1  issue strobe to the datapath.
REQ-013 o_fx_sample  out  bits_per_level  issued sample.
REQ-014 o_fx_gain  out  gain_size  gain applied by the datapath; held stable between issues.
REQ-015 i_fx_valid  in  1  datapath result strobe (results return in issue order, no backpressure).
REQ-016 i_fx_sample  in  fxp_size  datapath result.
REQ-017 o_valid_a / o_valid_b  out  1 each  one-cycle result strobe per channel.
REQ-018 o_sample_a / o_sample_b  out  fxp_size each  per-channel result, held until the next result for that channel.
REQ-019 o_busy  out  1  any sample held or in flight.
REQ-020 o_err  out  1  sticky: result with no tag, or input strobe while holding register full.

Function
REQ-021 A channel's strobe while o_ready is 1 SHALL load its holding register (sample + gain) and drop o_ready next cycle.
REQ-022 A strobe while o_ready is 0 SHALL be dropped and SHALL set o_err.
REQ-023 FSM states SHALL be IDLE, GAP, DRAIN.
REQ-024 IDLE: if a holding register is full, tag FIFO not full, and selected gain equals o_fx_gain or tag FIFO empty, SHALL issue (o_fx_valid=1 for one cycle, push channel tag, free holding register) and go to GAP.
REQ-025 IDLE: if selected gain differs from o_fx_gain and tag FIFO non-empty, SHALL go to DRAIN without issuing.
REQ-026 DRAIN: SHALL wait until tag FIFO empty, then return to IDLE; o_fx_gain updates only with an issue.
REQ-027 GAP: SHALL count issue_gap-1 cycles then return to IDLE; with issue_gap=1, GAP lasts 0 cycles (IDLE directly).
REQ-028 Both channels full: round-robin, pointer toggles after each issue; after reset A has priority.
REQ-029 o_fx_sample, o_fx_gain, o_fx_valid SHALL be registered (issue = one cycle after decision).
REQ-030 i_fx_valid SHALL pop the tag FIFO and, next cycle, assert o_valid and update o_sample of the tagged channel (latency 1).
REQ-031 i_fx_valid with empty tag FIFO SHALL set o_err and produce no output strobe.
REQ-032 Push and pop in the same cycle SHALL leave FIFO count unchanged; pointers wrap modulo tag_depth.
REQ-033 A strobe into an empty holding register in the same cycle that register issues cannot occur (issue requires full register); a strobe in the cycle the register is freed SHALL be accepted next cycle only (o_ready registered).

Reset
REQ-034 rst low SHALL asynchronously clear: FSM to IDLE, holding registers empty, o_ready_a/b=1, o_fx_valid=0, o_fx_sample=0, o_fx_gain=0, tag FIFO empty, RR pointer to A, o_valid_a/b=0, o_sample_a/b=0, o_busy=0, o_err=0.
REQ-035 Reset mid-operation SHALL discard in-flight tags; later i_fx_valid results SHALL set o_err.

Structure
REQ-036 FSM state enum, channel tag type (A=0, B=1) SHALL live in shared package effects_pkg.
REQ-037 Tag FIFO SHALL be sub-module tag_fifo (depth tag_depth, width 1, count output).

Verification
REQ-038 A only: sample 0x123, gain 0x010; return 0x0246 two cycles after issue -> o_valid_a with 0x0246, o_valid_b stays 0.
REQ-039 A and B strobe same cycle, equal gain 0x010 -> issue order A, B, A, B spaced issue_gap=2 cycles; results routed to correct channel.
REQ-040 A gain 0x010 in flight, B gain 0x020 pending -> FSM enters DRAIN, B issues only after A's result pops, o_fx_gain changes to 0x020 on that issue.
REQ-041 Second strobe on A while A full -> o_err=1 and sticky until reset; first sample still processed.
REQ-042 i_fx_valid with nothing issued -> o_err=1, no o_valid.
REQ-043 Issue tag_depth samples with no returns -> no further issue until a pop; rst low mid-flight -> all outputs at reset values immediately.
